icache_fill: RTL and testbench
==============================

ICACHE_FILL -- requirements
Module: icache_fill

Interface
REQ-001 Parameters: LINE_WORDS, 16, words per line; NUM_LINES, 16, cache entries.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 miss_req  in  1  requester level: held high from miss until fill_done.
REQ-005 miss_addr  in  32  missing byte address; stable while miss_req high.
REQ-006 flush_req  in  1  one-cycle pulse: invalidate all entries.
REQ-007 busy  out  1  high in any non-IDLE state.
REQ-008 fill_done  out  1  one-cycle pulse when a line becomes valid.
REQ-009 mem_req / mem_addr  out  1 / 32  word read request and word-aligned address.
REQ-010 mem_ack / mem_data  in  1 / 32  memory accepts request and returns data in same cycle.
REQ-011 dw_we / dw_idx / dw_word / dw_data  out  1 / 4 / 4 / 32  data-array write port.
REQ-012 tw_we / tw_idx / tw_tag / tw_valid  out  1 / 4 / 22 / 1  tag/valid-array write port.

Function
REQ-013 Address split: word [5:2], index [9:6], tag [31:10]; bits [1:0] ignored.
REQ-014 States: IDLE, FLUSH, KILL, FILL, COMMIT.
REQ-015 IDLE: flush_req -> FLUSH; else miss_req -> KILL, latching tag and index; flush_req wins when both present.
REQ-016 FLUSH: one tw_we per cycle, tw_valid=0, tw_idx counting 0..15; after index 15 -> IDLE; takes exactly 16 cycles.
REQ-017 KILL: one cycle, tw_we=1, tw_valid=0, tw_idx=latched index (no stale hit during partial fill); -> FILL with word counter 0.
REQ-018 FILL: mem_req=1, mem_addr={tag,index,word,2'b00}, held stable until mem_ack.
REQ-019 FILL on mem_ack: dw_we=1, dw_idx=index, dw_word=counter, dw_data=mem_data, same cycle; counter +1.
REQ-020 Ack with counter=15 -> COMMIT; counter wraps to 0, never exceeds 15.
REQ-021 Without mem_ack, state and counter unchanged; no dw_we.
REQ-022 COMMIT: one cycle, tw_we=1, tw_valid=1, tw_tag/tw_idx latched values, fill_done=1; -> IDLE.
REQ-023 Fill latency with zero-wait memory: miss seen -> fill_done = 18 cycles (KILL 1, FILL 16, COMMIT 1).
REQ-024 flush_req outside IDLE is dropped; miss_req ignored outside IDLE.
REQ-025 A miss_req still high in the cycle after fill_done starts a new fill (requester must drop it).
REQ-026 dw_we and tw_we never asserted in the same cycle; at most one write per array per cycle.
REQ-027 All write-port data/index outputs are 0 when their enable is low.

Reset
REQ-028 rst asserted -> immediately IDLE, counters 0, all outputs 0, latched tag/index 0.
REQ-029 rst mid-fill abandons the line; KILL already left it invalid; no tw_valid=1 issued.
REQ-030 Cache contents are not cleared by reset; software issues flush_req after reset.

Structure
REQ-031 Shared package icache_pkg: field widths (tag 22, index 4, word 4), LINE_WORDS, NUM_LINES, state enum.
REQ-032 Single flat module; no sub-module; arrays live in the cache, not here.

Verification
REQ-033 After rst, flush_req -> tw_we 16 consecutive cycles, tw_idx 0..15, tw_valid=0; busy 16 cycles.
REQ-034 miss_addr=0x0000_1A48, mem_ack always 1 -> KILL idx 9, mem_addr 0x1A40..0x1A7C, dw_word 0..15, COMMIT tag 0x6, fill_done cycle 18.
REQ-035 Same miss, mem_ack every third cycle -> mem_addr held between acks, 16 dw_we total, fill_done once.
REQ-036 flush_req and miss_req same cycle in IDLE -> FLUSH first, then fill begins at cycle 17.
REQ-037 rst asserted after 5th data ack -> outputs 0 same cycle, no tw_valid=1, next miss restarts at word 0.
REQ-038 flush_req during FILL -> ignored; fill completes; no tw_valid=0 after KILL.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared widths, line geometry and state encoding for the instruction-cache fill engine.
package icache_pkg;
    localparam int LINE_WORDS = 16;
    localparam int NUM_LINES  = 16;
    localparam int TAG_W      = 22;
    localparam int IDX_W      = 4;
    localparam int WORD_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_KILL,
        ST_FILL,
        ST_COMMIT
    } state_t;
endpackage

// File: rtl/icache_fill.sv
// I-cache line fill/flush sequencer: invalidates, fetches LINE_WORDS words, then validates the line.
// Miss to fill_done is LINE_WORDS+2 cycles with zero-wait memory; mem_ack stalls FILL, requests are only taken in IDLE.
module icache_fill
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = icache_pkg::LINE_WORDS,
    parameter int NUM_LINES  = icache_pkg::NUM_LINES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_req,
    input  logic [31:0]       miss_addr,
    input  logic              flush_req,
    output logic              busy,
    output logic              fill_done,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_data,
    output logic              dw_we,
    output logic [IDX_W-1:0]  dw_idx,
    output logic [WORD_W-1:0] dw_word,
    output logic [31:0]       dw_data,
    output logic              tw_we,
    output logic [IDX_W-1:0]  tw_idx,
    output logic [TAG_W-1:0]  tw_tag,
    output logic              tw_valid
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WORD_W-1:0]  r_cnt;
    logic [WORD_W-1:0]  w_cnt_nxt;
    logic [TAG_W-1:0]   r_tag;
    logic [IDX_W-1:0]   r_idx;
    logic               w_accept_miss;
    logic               w_last_word;
    logic               w_last_line;
    logic               w_unused;

    // Word offset and byte bits of the miss address are not needed: fills always start at word 0.
    assign w_unused      = ^miss_addr[5:0];
    assign w_accept_miss = (r_state == ST_IDLE) && !flush_req && miss_req;
    assign w_last_word   = (r_cnt == WORD_W'(LINE_WORDS - 1));
    assign w_last_line   = (r_cnt == WORD_W'(NUM_LINES - 1));
    assign busy          = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_tag   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept_miss) begin
                r_tag <= miss_addr[31:10];
                r_idx <= miss_addr[9:6];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        fill_done   = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        dw_we       = 1'b0;
        dw_idx      = '0;
        dw_word     = '0;
        dw_data     = '0;
        tw_we       = 1'b0;
        tw_idx      = '0;
        tw_tag      = '0;
        tw_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (flush_req) begin
                    w_state_nxt = ST_FLUSH;
                end else if (miss_req) begin
                    w_state_nxt = ST_KILL;
                end
            end
            ST_FLUSH: begin
                tw_we     = 1'b1;
                tw_idx    = r_cnt;
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_last_line) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            // Invalidate first so lookups never hit a partially written line.
            ST_KILL: begin
                tw_we       = 1'b1;
                tw_idx      = r_idx;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {r_tag, r_idx, r_cnt, 2'b00};
                if (mem_ack) begin
                    dw_we     = 1'b1;
                    dw_idx    = r_idx;
                    dw_word   = r_cnt;
                    dw_data   = mem_data;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_last_word) begin
                        w_state_nxt = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                tw_we       = 1'b1;
                tw_idx      = r_idx;
                tw_tag      = r_tag;
                tw_valid    = 1'b1;
                fill_done   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_fill.sv
// Scoreboard bench for icache_fill: expected writes/addresses queued at stimulus time, popped as the DUT emits them.
module tb_icache_fill;

    logic        clk;
    logic        rst;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic        flush_req;
    logic        busy;
    logic        fill_done;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        dw_we;
    logic [3:0]  dw_idx;
    logic [3:0]  dw_word;
    logic [31:0] dw_data;
    logic        tw_we;
    logic [3:0]  tw_idx;
    logic [21:0] tw_tag;
    logic        tw_valid;

    icache_fill dut (
        .clk       (clk),
        .rst       (rst),
        .miss_req  (miss_req),
        .miss_addr (miss_addr),
        .flush_req (flush_req),
        .busy      (busy),
        .fill_done (fill_done),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .dw_we     (dw_we),
        .dw_idx    (dw_idx),
        .dw_word   (dw_word),
        .dw_data   (dw_data),
        .tw_we     (tw_we),
        .tw_idx    (tw_idx),
        .tw_tag    (tw_tag),
        .tw_valid  (tw_valid)
    );

    typedef struct {
        logic [3:0]  idx;
        logic [3:0]  word;
        logic [31:0] data;
    } dw_exp_t;

    typedef struct {
        logic [3:0]  idx;
        logic [21:0] tag;
        logic        valid;
    } tw_exp_t;

    dw_exp_t     exp_dw[$];
    tw_exp_t     exp_tw[$];
    logic [31:0] exp_addr[$];

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int ack_ph = 0;
    logic ack_every3 = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_00C3;
    endfunction

    assign mem_data = mem_word(mem_addr);
    assign mem_ack  = ack_every3 ? (ack_ph == 0) : 1'b1;

    always begin
        @(posedge clk);
        #1;
        ack_ph = (ack_ph + 1) % 3;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    dw_exp_t mon_dw;
    tw_exp_t mon_tw;

    always @(negedge clk) begin
        if (!rst) begin
            if (dw_we && tw_we) chk("dw_tw_same_cycle", 1, 0);
            if (dw_we) begin
                if (exp_dw.size() == 0) chk("dw_unexpected", 1, 0);
                else begin
                    mon_dw = exp_dw.pop_front();
                    chk("dw_idx", dw_idx, mon_dw.idx);
                    chk("dw_word", dw_word, mon_dw.word);
                    chk("dw_data", dw_data, mon_dw.data);
                end
            end else begin
                chk("dw_idle_zero", {dw_idx, dw_word, dw_data}, 0);
            end
            if (tw_we) begin
                if (exp_tw.size() == 0) chk("tw_unexpected", {tw_idx, tw_tag, tw_valid}, 0);
                else begin
                    mon_tw = exp_tw.pop_front();
                    chk("tw_idx", tw_idx, mon_tw.idx);
                    chk("tw_tag", tw_tag, mon_tw.tag);
                    chk("tw_valid", tw_valid, mon_tw.valid);
                end
            end else begin
                chk("tw_idle_zero", {tw_idx, tw_tag, tw_valid}, 0);
            end
            if (mem_req) begin
                if (exp_addr.size() == 0) chk("memreq_unexpected", mem_addr, 0);
                else begin
                    chk("mem_addr", mem_addr, exp_addr[0]);
                    if (mem_ack) void'(exp_addr.pop_front());
                end
            end else begin
                chk("mem_addr_idle", mem_addr, 0);
            end
            if (fill_done) n_done++;
        end
    end

    task automatic push_flush();
        tw_exp_t t;
        for (int i = 0; i < 16; i++) begin
            t.idx = 4'(i); t.tag = '0; t.valid = 1'b0;
            exp_tw.push_back(t);
        end
    endtask

    task automatic push_fill(input logic [31:0] addr, input int nwords, input bit commit);
        tw_exp_t t;
        dw_exp_t d;
        logic [31:0] a;
        t.idx = addr[9:6]; t.tag = '0; t.valid = 1'b0;
        exp_tw.push_back(t);
        for (int w = 0; w < nwords; w++) begin
            a = {addr[31:6], 4'(w), 2'b00};
            exp_addr.push_back(a);
            d.idx = addr[9:6]; d.word = 4'(w); d.data = mem_word(a);
            exp_dw.push_back(d);
        end
        if (commit) begin
            t.idx = addr[9:6]; t.tag = addr[31:10]; t.valid = 1'b1;
            exp_tw.push_back(t);
        end
    endtask

    task automatic check_drained(input string nm);
        chk({nm, "_dw_left"}, exp_dw.size(), 0);
        chk({nm, "_tw_left"}, exp_tw.size(), 0);
        chk({nm, "_addr_left"}, exp_addr.size(), 0);
    endtask

    // flush_at: -1 none, 0 together with the miss, >0 pulse that many cycles into the fill.
    task automatic do_fill(input logic [31:0] addr, input bit every3, input int flush_at,
                           input int exp_lat, input string nm);
        int base;
        int n;
        bit seen;
        base = n_done;
        n = 0;
        seen = 1'b0;
        ack_every3 = every3;
        if (flush_at == 0) push_flush();
        push_fill(addr, 16, 1'b1);
        @(posedge clk);
        #1;
        miss_addr = addr;
        miss_req  = 1'b1;
        if (flush_at == 0) flush_req = 1'b1;
        while (!seen && n < 400) begin
            @(posedge clk);
            n++;
            #1;
            flush_req = (flush_at > 0 && n == flush_at);
            @(negedge clk);
            if (fill_done) seen = 1'b1;
        end
        miss_req = 1'b0;
        flush_req = 1'b0;
        chk({nm, "_fill_done_seen"}, seen, 1);
        if (exp_lat > 0) chk({nm, "_latency"}, n, exp_lat);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({nm, "_done_count"}, n_done - base, 1);
        chk({nm, "_idle_busy"}, busy, 0);
        check_drained(nm);
    endtask

    initial begin
        int nb;
        int ndw;
        rst = 1'b1;
        miss_req = 1'b0;
        miss_addr = '0;
        flush_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {busy, fill_done, mem_req, dw_we, tw_we}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_dw", {dw_idx, dw_word, dw_data}, 0);
        chk("rst_tw", {tw_idx, tw_tag, tw_valid}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // flush after reset
        push_flush();
        @(posedge clk);
        #1 flush_req = 1'b1;
        @(posedge clk);
        #1 flush_req = 1'b0;
        nb = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) nb++;
        end
        chk("flush_busy_cycles", nb, 16);
        check_drained("flush");

        do_fill(32'h0000_1A48, 1'b0, -1, 18, "fill_zw");
        do_fill(32'h0000_1A48, 1'b1, -1, 0, "fill_ack3");
        do_fill(32'h0000_3C84, 1'b0, 0, 35, "flush_miss");

        // reset after the 5th data ack
        ack_every3 = 1'b0;
        push_fill(32'h0000_1A48, 5, 1'b0);
        @(posedge clk);
        #1;
        miss_addr = 32'h0000_1A48;
        miss_req = 1'b1;
        ndw = 0;
        for (int k = 0; k < 100 && ndw < 5; k++) begin
            @(negedge clk);
            if (dw_we) ndw++;
        end
        chk("rst_mid_acks", ndw, 5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        miss_req = 1'b0;
        #1;
        chk("rstmid_ctl", {busy, fill_done, mem_req, dw_we, tw_we}, 0);
        chk("rstmid_mem_addr", mem_addr, 0);
        chk("rstmid_dw", {dw_idx, dw_word, dw_data}, 0);
        chk("rstmid_tw", {tw_idx, tw_tag, tw_valid}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_drained("rstmid");
        do_fill(32'hDEAD_BEEC, 1'b0, -1, 18, "after_rst");

        do_fill(32'h0001_2340, 1'b0, 6, 18, "flush_in_fill");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
